// File: rtl/alu_mult_sequencer.sv
// alu_mult_sequencer: unsigned shift-add multiplier that time-shares
// the external 4-op ALU, issuing one add per multiplier bit.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start, op_a, op_b request and unsigned operands (captured on accept)
//   busy, done        busy in RUN/DONE, done is a one-cycle pulse
//   product           last completed 2*WIDTH-bit product
//   alu_src_a/b       ALU operands, WIDTH+1 bits so the carry survives
//   alu_control       ALU op select, always add
//   alu_out, alu_zero ALU result and zero flag (zero flag unused)
module alu_mult_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic [WIDTH:0]     alu_src_a,
   output logic [WIDTH:0]     alu_src_b,
   output logic [1:0]         alu_control,
   input  logic [WIDTH:0]     alu_out,
   input  logic               alu_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] m_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [CW-1:0]    cnt_q;
   logic             last;
   logic             zero_op;
   logic             unused_alu_zero;

   assign last            = (cnt_q == CW'(WIDTH - 1));
   assign zero_op         = (op_a == '0) || (op_b == '0);
   assign unused_alu_zero = alu_zero;

   // ALU is driven purely from registers, so it only ever adds
   // the accumulator and (conditionally) the multiplicand.
   assign alu_src_a   = {1'b0, hi_q};
   assign alu_src_b   = lo_q[0] ? {1'b0, m_q} : '0;
   assign alu_control = 2'b00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = zero_op ? DONE : RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Each RUN edge shifts {carry, sum, lo} right by one: the sum's
   // LSB drops into lo as a finished product bit while the next
   // multiplier bit moves into lo[0].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         product <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  m_q   <= op_a;
                  hi_q  <= '0;
                  lo_q  <= op_b;
                  cnt_q <= '0;
                  if (zero_op) begin
                     product <= '0;
                  end
               end
            end
            RUN: begin
               hi_q  <= alu_out[WIDTH:1];
               lo_q  <= {alu_out[0], lo_q[WIDTH-1:1]};
               cnt_q <= cnt_q + CW'(1);
               if (last) begin
                  product <= {alu_out[WIDTH:1], alu_out[0],
                              lo_q[WIDTH-1:1]};
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// tb_alu_mult_sequencer: drives alu_mult_sequencer with a behavioural
// ALU and checks products, handshake timing and reset behaviour.
module tb_alu_mult_sequencer;

   localparam int W = 8;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [W-1:0]   op_a;
   logic [W-1:0]   op_b;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;
   logic [W:0]     alu_src_a;
   logic [W:0]     alu_src_b;
   logic [1:0]     alu_control;
   logic [W:0]     alu_out;
   logic           alu_zero;

   int n_tests = 0;
   int n_fail  = 0;

   alu_mult_sequencer #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op_a        (op_a),
      .op_b        (op_b),
      .busy        (busy),
      .done        (done),
      .product     (product),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .alu_control (alu_control),
      .alu_out     (alu_out),
      .alu_zero    (alu_zero)
   );

   // Shared 4-op ALU, WIDTH+1 bits wide.
   always_comb begin
      alu_out = '0;
      case (alu_control)
         2'b00:   alu_out = alu_src_a + alu_src_b;
         2'b01:   alu_out = alu_src_a - alu_src_b;
         2'b10:   alu_out = alu_src_a & alu_src_b;
         default: alu_out = alu_src_a | alu_src_b;
      endcase
      alu_zero = (alu_out == '0);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge
   // with the DUT idle again. Latency counts edges after the accept
   // edge until done is seen.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input string tag);
      logic [2*W-1:0] exp;
      int             exp_lat;
      int             lat;
      logic           seen;
      logic           ctl_ok;
      int             k;
      exp     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      exp_lat = (a == 0 || b == 0) ? 0 : W;
      start = 1'b1;
      op_a  = a;
      op_b  = b;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      op_a  = W'($urandom);
      op_b  = W'($urandom);
      check({tag, "_busy_on"}, busy, 1'b1);
      seen   = done;
      lat    = 0;
      ctl_ok = (alu_control == 2'b00);
      k      = 0;
      while (!seen && k < 40) begin
         @(posedge clk);
         @(negedge clk);
         k++;
         if (alu_control != 2'b00) ctl_ok = 1'b0;
         if (done) begin
            seen = 1'b1;
            lat  = k;
         end
      end
      check({tag, "_done_seen"}, seen, 1'b1);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_product"}, product, exp);
      check({tag, "_alu_ctl"}, ctl_ok, 1'b1);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_done_1cyc"}, done, 1'b0);
      check({tag, "_busy_off"}, busy, 1'b0);
   endtask

   initial begin
      int             nd;
      int             e1;
      int             e2;
      logic [2*W-1:0] p1;
      logic [2*W-1:0] p2;
      logic [W-1:0]   ra;
      logic [W-1:0]   rb;
      int             dseen;

      rst_n = 1'b0;
      start = 1'b0;
      op_a  = '0;
      op_b  = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_product", product, 0);
      check("rst_src_a", alu_src_a, 0);
      check("rst_src_b", alu_src_b, 0);
      check("rst_ctl", alu_control, 2'b00);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(8'd13, 8'd11, "m13x11");
      check("m13x11_const", product, 16'h008F);
      repeat (3) @(negedge clk);
      check("hold_idle", product, 16'h008F);
      run_op(8'd255, 8'd255, "m255x255");
      check("m255x255_const", product, 16'hFE01);
      run_op(8'd0, 8'd200, "m0x200");
      run_op(8'd5, 8'd6, "m5x6");
      run_op(8'd77, 8'd0, "m77x0");

      // start held high across a whole operation and its done cycle
      nd = 0;
      e1 = -1;
      e2 = -1;
      p1 = '0;
      p2 = '0;
      for (int e = 0; e <= 30; e++) begin
         start = (e <= 10);
         op_a  = (e == 0) ? 8'd3 : 8'd9;
         op_b  = (e == 0) ? 8'd5 : 8'd9;
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            nd++;
            if (nd == 1) begin
               e1 = e;
               p1 = product;
            end else if (nd == 2) begin
               e2 = e;
               p2 = product;
            end
         end
      end
      start = 1'b0;
      check("hold_ndone", nd, 2);
      check("hold_edge1", e1, 8);
      check("hold_prod1", p1, 15);
      check("hold_edge2", e2, 18);
      check("hold_prod2", p2, 81);

      // asynchronous reset in the middle of 200*100
      start = 1'b1;
      op_a  = 8'd200;
      op_b  = 8'd100;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 1'b0);
      check("arst_done", done, 1'b0);
      check("arst_product", product, 0);
      check("arst_src_a", alu_src_a, 0);
      check("arst_src_b", alu_src_b, 0);
      dseen = 0;
      repeat (2) begin
         @(negedge clk);
         if (done) dseen++;
      end
      check("arst_no_done", dseen, 0);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(8'd6, 8'd7, "m6x7");
      check("m6x7_const", product, 42);

      for (int i = 0; i < 3000; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         if ($urandom_range(0, 15) == 0) ra = '0;
         if ($urandom_range(0, 15) == 0) rb = '0;
         run_op(ra, rb, "rand");
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
